// File: rtl/nn_layer_pkg.sv
// Shared types and helpers for the time-multiplexed neuron layer engine.
// Keeps width math and saturation rules in one place.
package nn_layer_pkg;

  typedef enum logic [1:0] {IDLE, FWD, UPD, DONE} state_t;

  function automatic int acc_width(input int ww, input int xw, input int n_in);
    return ww + xw + $clog2(n_in) + 1;
  endfunction

  // Clamp a signed value into the two's-complement range of the given width.
  function automatic longint sat_signed(input longint v, input int width);
    longint hi;
    longint lo;
    hi = (longint'(1) << (width - 1)) - 1;
    lo = -(longint'(1) << (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint default_weight(input int i, input int ww);
    return sat_signed(longint'(i + 1), ww);
  endfunction

endpackage

// File: rtl/nn_layer_engine_sat_mac.sv
// Single shared datapath: one multiply per cycle feeding the forward accumulator
// (with ReLU/saturation) and the saturating weight-update path.
module sat_mac
  import nn_layer_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int XW       = 1,
  parameter int WW       = 8,
  parameter int EW       = 8,
  parameter int AW       = 10,
  parameter int LR_SHIFT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 acc_en,
  input  logic                 acc_clr,
  input  logic signed [WW-1:0] w,
  input  logic [XW-1:0]        x,
  input  logic signed [EW-1:0] err,
  output logic [AW-1:0]        act,
  output logic signed [WW-1:0] w_upd
);

  localparam int ACCW = acc_width(WW, XW, N_IN);
  localparam int PW   = WW + XW + 1;
  localparam int GW   = EW + XW + 1;

  logic signed [ACCW-1:0] acc_q;
  logic signed [ACCW-1:0] acc_sum;
  logic signed [PW-1:0]   prod;
  logic signed [GW-1:0]   grad;
  longint                 acc_l;
  longint                 diff;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    prod    = PW'(w) * PW'($signed({1'b0, x}));
    acc_sum = (acc_clr ? ACCW'(0) : acc_q) + ACCW'(prod);
    acc_l   = longint'(acc_sum);
    act     = '0;
    if (acc_l >= 0) begin
      if (acc_l > (longint'(1) << AW) - 1) act = '1;
      else                                 act = AW'(acc_l);
    end
    grad  = GW'(err) * GW'($signed({1'b0, x}));
    diff  = longint'(w) - longint'(grad >>> LR_SHIFT);
    w_upd = WW'(sat_signed(diff, WW));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      acc_q <= '0;
    else if (acc_en) acc_q <= acc_sum;
  end

endmodule

// File: rtl/nn_layer_engine.sv
// Fully-connected layer of N_OUT neurons over N_IN inputs, one weight per cycle,
// with forward (ReLU) and in-place weight-update passes behind a start/done handshake.
module nn_layer_engine
  import nn_layer_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int N_OUT    = 2,
  parameter int XW       = 1,
  parameter int WW       = 8,
  parameter int EW       = 8,
  parameter int AW       = 10,
  parameter int LR_SHIFT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic                  init_i,
  input  logic [N_IN*XW-1:0]    x_i,
  input  logic [N_OUT*EW-1:0]   err_i,
  output logic [N_OUT*AW-1:0]   act_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int NW   = N_OUT * N_IN;
  localparam int IW   = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int IDXW = (NW    > 1) ? $clog2(NW)    : 1;

  state_t                 state_q, state_d;
  logic [IW-1:0]          i_q;
  logic [JW-1:0]          j_q;
  int                     ii, jj;
  logic [IDXW-1:0]        idx;
  logic                   accept, last_i, last_step, do_init;
  logic [N_IN*XW-1:0]     x_q;
  logic [N_OUT*EW-1:0]    err_q;
  logic signed [WW-1:0]   w_q [NW];
  logic [AW-1:0]          shadow_q [N_OUT];
  logic [N_OUT*AW-1:0]    act_q, act_next;
  logic                   busy_q, done_q;
  logic [AW-1:0]          mac_act;
  logic signed [WW-1:0]   mac_w_upd;

  assign ii        = int'(i_q);
  assign jj        = int'(j_q);
  assign idx       = IDXW'(jj * N_IN + ii);
  assign last_i    = (ii == N_IN - 1);
  assign last_step = last_i && (jj == N_OUT - 1);
  assign do_init   = (state_q == IDLE) && init_i;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // init has priority; a start arriving with it is dropped
        if (start_i && !init_i) begin
          accept  = 1'b1;
          state_d = mode_i ? UPD : FWD;
        end
      end
      FWD, UPD: if (last_step) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      x_q     <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (accept) begin
        x_q   <= x_i;
        err_q <= err_i;
      end
      if (state_q == FWD || state_q == UPD) begin
        if (last_i) begin
          i_q <= '0;
          j_q <= last_step ? '0 : j_q + 1'b1;
        end else begin
          i_q <= i_q + 1'b1;
        end
      end else if (state_q == DONE) begin
        i_q <= '0;
        j_q <= '0;
      end
    end
  end

  sat_mac #(
    .N_IN(N_IN), .XW(XW), .WW(WW), .EW(EW), .AW(AW), .LR_SHIFT(LR_SHIFT)
  ) u_mac (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .acc_en (state_q == FWD),
    .acc_clr(ii == 0),
    .w      (w_q[idx]),
    .x      (x_q[ii*XW +: XW]),
    .err    ($signed(err_q[jj*EW +: EW])),
    .act    (mac_act),
    .w_upd  (mac_w_upd)
  );

  // NOTE: the weight array is a register file, not RAM, so it is reset to defaults like any flop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < NW; k++) w_q[k] <= WW'(default_weight(k % N_IN, WW));
    end else if (do_init) begin
      for (int k = 0; k < NW; k++) w_q[k] <= WW'(default_weight(k % N_IN, WW));
    end else if (state_q == UPD) begin
      w_q[idx] <= mac_w_upd;
    end
  end

  // Final neuron bypasses the shadow so all activations land together with done_o.
  always_comb begin
    act_next = '0;
    for (int j = 0; j < N_OUT; j++)
      act_next[j*AW +: AW] = (j == jj) ? mac_act : shadow_q[j];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int j = 0; j < N_OUT; j++) shadow_q[j] <= '0;
      act_q <= '0;
    end else if (state_q == FWD && last_i) begin
      shadow_q[j_q] <= mac_act;
      if (last_step) act_q <= act_next;
    end
  end

  assign act_o  = act_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_nn_layer_engine.sv
// Directed self-checking bench for nn_layer_engine at default parameters.
module tb_nn_layer_engine;

  logic        clk_i   = 1'b0;
  logic        rst_i   = 1'b0;
  logic        start_i = 1'b0;
  logic        mode_i  = 1'b0;
  logic        init_i  = 1'b0;
  logic [3:0]  x_i     = '0;
  logic [15:0] err_i   = '0;
  logic [19:0] act_o;
  logic        busy_o;
  logic        done_o;

  int tests = 0;
  int fails = 0;

  nn_layer_engine dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(start_i),
    .mode_i (mode_i),
    .init_i (init_i),
    .x_i    (x_i),
    .err_i  (err_i),
    .act_o  (act_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_act(input string tag, input int exp1, input int exp0);
    check({tag, ".act0"}, longint'(act_o[9:0]),   longint'(exp0));
    check({tag, ".act1"}, longint'(act_o[19:10]), longint'(exp1));
  endtask

  // Issue one pass; optionally scramble inputs and pulse start/init while busy.
  task automatic run_pass(input string tag, input logic m, input logic [3:0] x,
                          input logic [15:0] err, input bit poke);
    int n;
    bit busy_ok;
    @(negedge clk_i);
    start_i = 1'b1; mode_i = m; x_i = x; err_i = err;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!done_o && n < 40) begin
      if (!busy_o) busy_ok = 1'b0;
      if (poke && n == 3) begin
        x_i = ~x; err_i = 16'h7f81; start_i = 1'b1; init_i = 1'b1;
      end else begin
        start_i = 1'b0; init_i = 1'b0;
      end
      @(negedge clk_i);
      n++;
    end
    start_i = 1'b0; init_i = 1'b0;
    if (!busy_o) busy_ok = 1'b0;
    check({tag, ".done_cycle"}, n, 9);
    check({tag, ".busy_1_9"}, busy_ok, 1);
  endtask

  task automatic after_done(input string tag);
    @(negedge clk_i);
    check({tag, ".busy_fall"}, busy_o, 0);
    check({tag, ".done_pulse"}, done_o, 0);
  endtask

  task automatic do_init(input logic with_start);
    @(negedge clk_i);
    init_i = 1'b1; start_i = with_start; mode_i = 1'b0;
    @(negedge clk_i);
    init_i = 1'b0; start_i = 1'b0;
    check("init.busy", busy_o, 0);
  endtask

  initial begin
    bit seen_done;

    repeat (2) @(negedge clk_i);
    check("reset.act", act_o, 0);
    check("reset.busy", busy_o, 0);
    check("reset.done", done_o, 0);
    rst_i = 1'b1;

    // Defaults, all inputs on: each neuron sums 1+2+3+4.
    run_pass("fwd1111", 1'b0, 4'b1111, 16'h0000, 1'b0);
    check_act("fwd1111", 10, 10);
    after_done("fwd1111");

    // x[0] and x[2]: 1+3; inputs and start/init disturbed mid-pass.
    run_pass("fwd0101", 1'b0, 4'b0101, 16'h0000, 1'b1);
    check_act("fwd0101", 4, 4);
    after_done("fwd0101");

    // err0=+8: delta 1 on every neuron-0 weight -> 0,1,2,3.
    run_pass("upd8", 1'b1, 4'b1111, 16'h0008, 1'b0);
    check_act("upd8.keep", 4, 4);
    after_done("upd8");
    run_pass("fwd_after_upd8", 1'b0, 4'b1111, 16'h0000, 1'b1);
    check_act("fwd_after_upd8", 10, 6);

    // init together with start: init wins, no pass begins.
    do_init(1'b1);
    check_act("init.keep", 10, 6);

    // err0=+127: delta 15 -> -14,-13,-12,-11; ReLU clamps neuron 0.
    run_pass("upd127", 1'b1, 4'b1111, 16'h007f, 1'b0);
    run_pass("fwd_relu", 1'b0, 4'b1111, 16'h0000, 1'b0);
    check_act("fwd_relu", 10, 0);

    // err0=-128 on x[0]: w[0][0] climbs by 16 per update, saturating at 127.
    do_init(1'b0);
    for (int k = 1; k <= 8; k++) begin
      int exp0;
      exp0 = (1 + 16 * k > 127) ? 127 : 1 + 16 * k;
      run_pass("upd_sat", 1'b1, 4'b0001, 16'h0080, 1'b0);
      run_pass("fwd_sat", 1'b0, 4'b0001, 16'h0000, 1'b0);
      check_act($sformatf("sat%0d", k), 1, exp0);
    end
    do_init(1'b0);
    run_pass("fwd_restored", 1'b0, 4'b0001, 16'h0000, 1'b0);
    check_act("fwd_restored", 1, 1);

    // Reset in the middle of a forward pass.
    @(negedge clk_i);
    start_i = 1'b1; mode_i = 1'b0; x_i = 4'b1111;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_mid.act", act_o, 0);
    check("rst_mid.busy", busy_o, 0);
    check("rst_mid.done", done_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk_i);
      if (done_o) seen_done = 1'b1;
    end
    check("rst_mid.no_done", seen_done, 0);
    run_pass("fwd_after_rst", 1'b0, 4'b1111, 16'h0000, 1'b0);
    check_act("fwd_after_rst", 10, 10);
    after_done("fwd_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_layer_engine.md
# nn_layer_engine

Parametrised, time-multiplexed fully-connected neuron layer with on-chip weight storage and an in-place gradient-update mode. It generalises the fixed 4-input, 2-neuron hidden/output neuron and backprop pair into one engine with N_IN inputs and N_OUT neurons. Everything shares a single multiply-accumulate datapath that processes one weight per cycle. The training state machine drives it with a start/mode/done handshake for both forward and weight-update passes.

## Interface
- N_IN, 4: inputs per neuron
- N_OUT, 2: neurons in layer
- XW, 1: unsigned input element width
- WW, 8: signed two's-complement weight width
- EW, 8: signed error width per neuron
- AW, 10: unsigned activation width
- LR_SHIFT, 3: learning-rate right shift (arithmetic)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  begin a pass; accepted only in IDLE
- mode_i  in  1  0 = forward, 1 = weight update; sampled with start_i
- init_i  in  1  reload default weights; acted on only in IDLE
- x_i  in  N_IN*XW  input vector, element i at [i*XW +: XW]
- err_i  in  N_OUT*EW  per-neuron error, neuron j at [j*EW +: EW]
- act_o  out  N_OUT*AW  activations, neuron j at [j*AW +: AW]
- busy_o  out  1  high whenever state ≠ IDLE
- done_o  out  1  one-cycle pulse when a pass completes

## Operation
- Default weights: w[j][i] = i+1 for every neuron j, truncated/saturated to WW.
- State machine:
  - IDLE → FWD on start_i with mode_i=0.
  - IDLE → UPD on start_i with mode_i=1.
  - FWD/UPD → DONE after N_OUT*N_IN steps.
  - DONE → IDLE unconditionally.
- On accept, x_i and err_i are latched. Later input changes have no effect on the pass in flight.
- Step counter: inner index i runs 0..N_IN-1, outer index j runs 0..N_OUT-1, one (j,i) per cycle. Both indices wrap to 0 on DONE.
- FWD accumulation:
  - acc is signed, ACCW = WW+XW+$clog2(N_IN)+1 bits.
  - acc cleared at i=0, then acc += w[j][i]*x[i].
  - After i=N_IN-1: act[j] = 0 if acc<0, else min(acc, 2^AW-1).
  - Activations are written into a shadow register.
  - The shadow copies to act_o in the DONE cycle, so all neurons update together.
- UPD: w[j][i] ← sat_WW(w[j][i] − ((err[j]*x[i]) >>> LR_SHIFT)). Saturation range is [−2^(WW−1), 2^(WW−1)−1].
- init_i in IDLE: all weights reload to defaults in one cycle. act_o is unchanged.
- init_i together with start_i in IDLE: init wins and start is dropped.
- start_i or init_i while busy: ignored, no queuing.
- Reset clears the following; a reset mid-pass aborts it without a done_o:
  - state = IDLE
  - counters = 0
  - act_o = 0
  - busy_o = 0
  - done_o = 0
  - weights = defaults

## Timing
- Accept edge E0 → busy_o=1 from the next cycle.
- N_OUT*N_IN step cycles follow, then DONE.
- done_o=1 and the new act_o appear in cycle N_OUT*N_IN+1 after E0. At defaults this is cycle 9.
- UPD has the same latency. act_o is unchanged by UPD.
- busy_o falls in the cycle after done_o.
- The earliest next start is accepted on the edge ending that cycle. Back-to-back passes have no extra idle cycle.
- Every output is registered. There are no combinational paths from inputs to outputs.

## Structure
- Package nn_layer_pkg holds:
  - state enum {IDLE, FWD, UPD, DONE}
  - the default-weight function
  - the saturation helper function
  - the ACCW width calculation
- Weights are a flat register array of N_OUT*N_IN entries, indexed j*N_IN+i.
- One sub-module, sat_mac, holds the single shared datapath:
  - multiply, accumulate/clear, ReLU plus saturation, and weight-delta saturation.
  - It is purely combinational plus the acc register.

## Test plan
- Reset, then defaults, x=4'b1111, forward → done_o in cycle 9 after accept, act_o = {10,10}, busy_o high for cycles 1–9.
- x=4'b0101 forward → act_o = {4,4}. Change x_i mid-pass → result still {4,4}.
- Update with err={0,+8}, x=4'b1111 → neuron 0 weights become 0,1,2,3. Then forward with x=1111 → act_o = {10,6} (neuron1, neuron0).
- Update with err0=+127 → neuron 0 weights become −14,−13,−12,−11. Forward → act0 = 0 (ReLU).
- Saturation: eight updates with err0=−128, x=4'b0001 → w[0][0] goes 17, 33, … then clamps at 127. init_i then restores it to 1.
- rst_i low mid-FWD → outputs zero immediately, no done_o. A new start completes normally. start_i or init_i pulsed while busy → no effect.
